i2s_tdm_rx: RTL and testbench
=============================

// Module: i2s_tdm_rx
// PURPOSE
//   Parametrised serial audio receiver: next generation of the stereo I2S receiver.
//   - Covers I2S (1-bit delay) and left-justified framing.
//   - Covers 2..8 slots per frame (TDM), with slot width >= sample width.
//   - Locks to the frame sync, checks frame length, delivers whole frames on a valid/ready handshake.
//   - Sits between the codec serial pins (sclk domain) and the audio packet FIFO/DSP path.
// PARAMETERS
//   WIDTH     16  sample bits captured per slot (MSB-first); 8..32
//   SLOT_BITS 16  sclk cycles per slot; >= WIDTH; trailing SLOT_BITS-WIDTH bits ignored
//   CHANNELS  2   slots per frame; 2..8
//   MODE      0   0 = I2S (MSB one sclk after WS edge); 1 = left-justified (MSB on WS edge)
// PORTS
//   sclk           in   1               bit clock; all logic on posedge sclk
//   rst            in   1               asynchronous, active-low reset
//   ws_i           in   1               word select / frame sync; transmitter changes it on negedge
//   sdata_i        in   1               serial data; transmitter changes it on negedge
//   frame_o        out  CHANNELS*WIDTH  slot n at [n*WIDTH +: WIDTH]; slot 0 = left
//   frame_valid_o  out  1               frame_o holds a complete unconsumed frame
//   frame_ready_i  in   1               consumer accepts on posedge with valid && ready
//   locked_o       out  1               receiver is aligned to frame sync
//   frame_err_o    out  1               1-cycle pulse: misplaced/missing frame sync
//   overrun_o      out  1               1-cycle pulse: completed frame dropped, holding reg full
// BEHAVIOUR
//   Reset (rst=0, async):
//     - frame_o=0, frame_valid_o=0, locked_o=0, frame_err_o=0, overrun_o=0.
//     - State HUNT, bit_cnt=0, shift regs cleared.
//     - Any partial frame is lost; no frame is emitted from pre-reset data.
//   Sampling: ws_i and sdata_i are sampled on posedge sclk. ws_d is the previous ws sample.
//   Frame start (FS): the edge where ws_i=0 and ws_d=1.
//     - FS is the only ws event used. For CHANNELS>2, ws level between FS events is ignored.
//   TOTAL = CHANNELS*SLOT_BITS. Bit k of the frame is the sdata sample k edges after frame bit 0.
//   Frame bit 0 (MSB of slot 0):
//     - MODE=1: sampled on the FS edge itself.
//     - MODE=0: sampled on the edge after FS.
//   FSM states:
//     - HUNT: locked_o=0; sdata ignored. FS -> RECV with bit_cnt aligned per MODE; locked_o=1 from next edge.
//     - RECV: each edge captures one bit. Bits with slot offset < WIDTH go to slot (bit_cnt / SLOT_BITS), MSB-first.
//   Frame completion: on the edge capturing bit TOTAL-1:
//     - frame_valid_o=0: assembled frame -> frame_o, frame_valid_o=1, visible after that edge.
//     - frame_valid_o=1 and ready=0: new frame dropped, frame_o unchanged, overrun_o pulses.
//     - Same-edge accept (valid && ready): old frame consumed, new frame loaded, valid stays 1, no overrun.
//   Handshake:
//     - frame_o is stable while frame_valid_o=1.
//     - valid clears on the accept edge unless a new frame loads on that same edge.
//   Sync check in RECV: expected FS edge is
//     - MODE=0: the edge capturing bit TOTAL-1.
//     - MODE=1: the edge that would capture bit TOTAL (bit 0 of next frame).
//   At the expected FS edge:
//     - FS present: next frame continues seamlessly, no gap.
//     - FS absent: frame_err_o pulse, locked_o->0, HUNT. A frame completed on that edge is still delivered.
//   FS on any other edge:
//     - frame_err_o pulse, partial frame discarded (not emitted).
//     - Realign to this FS immediately, staying in RECV with locked_o=1.
//   Errors never alter a frame already held in frame_o.
// TESTING
//   - MODE0, 2ch, 16/16: I2S frame L=DEAD R=BEEF -> frame_o=BEEF_DEAD, valid 1 edge after R LSB; ready=1 clears it.
//   - MODE1, 2ch: L=1234 R=ABCD left-justified -> frame_o=ABCD_1234; no frame_err.
//   - MODE0, CHANNELS=4, SLOT_BITS=32, WIDTH=24: slots 0xA5A5A5,0x123456,0xFFFFFF,0x000001, pad bits 0xFF -> pad ignored, exact slots.
//   - 2ch: FS after 20 bits of a 32-bit frame -> frame_err 1 pulse, no valid; next full frame 0x5555/0xAAAA delivered.
//   - frame_ready_i=0 over 3 frames -> frame_o = first frame throughout, overrun_o pulses twice.
//   - ready=1 on completion edge -> no overrun.
//   - rst low mid-slot, release, send 1 frame -> outputs 0 during reset, first valid only after a full post-reset frame.

Source files
------------

// File: rtl/i2s_tdm_rx.sv
// I2S / left-justified TDM serial audio receiver: locks to the frame sync,
// assembles CHANNELS slots per frame and hands whole frames over valid/ready.
module i2s_tdm_rx #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 16,
    parameter int CHANNELS  = 2,
    parameter int MODE      = 0
) (
    input  logic                      sclk,
    input  logic                      rst,
    input  logic                      ws_i,
    input  logic                      sdata_i,
    output logic [CHANNELS*WIDTH-1:0] frame_o,
    output logic                      frame_valid_o,
    input  logic                      frame_ready_i,
    output logic                      locked_o,
    output logic                      frame_err_o,
    output logic                      overrun_o
);

    localparam int OFF_W = $clog2(SLOT_BITS);
    localparam int SL_W  = $clog2(CHANNELS);
    localparam int FW    = CHANNELS * WIDTH;

    typedef enum logic {HUNT, RECV} state_t;

    state_t            state, state_n;
    logic              ws_d;
    logic [OFF_W-1:0]  off_q, off_n, cap_off, inc_off;
    logic [SL_W-1:0]   slot_q, slot_n, cap_slot, inc_slot;
    logic [FW-1:0]     acc_q, acc_n;
    logic              fs, first, last, off_wrap;
    logic              cap, done, err;

    assign fs       = ws_d & ~ws_i;
    assign first    = (off_q == '0) && (slot_q == '0);
    assign last     = (off_q == OFF_W'(SLOT_BITS-1)) && (slot_q == SL_W'(CHANNELS-1));
    assign locked_o = (state == RECV);

    // (slot_q, off_q) addresses the frame bit captured on the current edge
    assign off_wrap = (off_q == OFF_W'(SLOT_BITS-1));
    assign inc_off  = off_wrap ? '0 : off_q + 1'b1;
    assign inc_slot = !off_wrap ? slot_q :
                      (slot_q == SL_W'(CHANNELS-1)) ? '0 : slot_q + 1'b1;

    always_comb begin
        state_n  = state;
        off_n    = off_q;
        slot_n   = slot_q;
        cap      = 1'b0;
        cap_off  = off_q;
        cap_slot = slot_q;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            HUNT: begin
                off_n  = '0;
                slot_n = '0;
                if (fs) begin
                    state_n = RECV;
                    if (MODE != 0) begin
                        cap      = 1'b1;
                        cap_off  = '0;
                        cap_slot = '0;
                        off_n    = OFF_W'(1);
                    end
                end
            end
            default: begin
                if (MODE == 0) begin
                    // I2S: the next frame's sync coincides with our last bit
                    if (last) begin
                        cap    = 1'b1;
                        done   = 1'b1;
                        off_n  = '0;
                        slot_n = '0;
                        if (!fs) begin
                            err     = 1'b1;
                            state_n = HUNT;
                        end
                    end else if (fs) begin
                        err    = 1'b1;
                        off_n  = '0;
                        slot_n = '0;
                    end else begin
                        cap    = 1'b1;
                        off_n  = inc_off;
                        slot_n = inc_slot;
                    end
                end else begin
                    // Left-justified: sync edge also carries bit 0
                    if (fs) begin
                        err      = !first;
                        cap      = 1'b1;
                        cap_off  = '0;
                        cap_slot = '0;
                        off_n    = OFF_W'(1);
                        slot_n   = '0;
                    end else if (first) begin
                        err     = 1'b1;
                        state_n = HUNT;
                    end else begin
                        cap    = 1'b1;
                        done   = last;
                        off_n  = inc_off;
                        slot_n = inc_slot;
                    end
                end
            end
        endcase
    end

    // Pad bits (slot offset >= WIDTH) never match a target position
    always_comb begin
        acc_n = acc_q;
        for (int s = 0; s < CHANNELS; s++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (cap && cap_slot == SL_W'(s) && cap_off == OFF_W'(WIDTH-1-b))
                    acc_n[s*WIDTH+b] = sdata_i;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state         <= HUNT;
            ws_d          <= 1'b0;
            off_q         <= '0;
            slot_q        <= '0;
            acc_q         <= '0;
            frame_o       <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            state       <= state_n;
            ws_d        <= ws_i;
            off_q       <= off_n;
            slot_q      <= slot_n;
            acc_q       <= acc_n;
            frame_err_o <= err;
            overrun_o   <= 1'b0;
            if (done && (!frame_valid_o || frame_ready_i)) begin
                frame_o       <= acc_n;
                frame_valid_o <= 1'b1;
            end else if (done) begin
                overrun_o <= 1'b1;
            end else if (frame_valid_o && frame_ready_i) begin
                frame_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Directed bench for i2s_tdm_rx: three configurations share one serial line,
// each scenario resets and checks only the instance it targets.
module tb_i2s_tdm_rx;

    logic sclk, rst, ws, sd, rdy;
    logic [31:0] fr_a, fr_b;
    logic [95:0] fr_c;
    logic v_a, lk_a, er_a, ov_a;
    logic v_b, lk_b, er_b, ov_b;
    logic v_c, lk_c, er_c, ov_c;

    int n_vec = 0, n_bad = 0;
    int er_a_n = 0, ov_a_n = 0, vr_a_n = 0, er_b_n = 0, hold_bad = 0;
    logic vprev_a = 1'b0;
    logic chk_hold = 1'b0;
    logic [31:0] hold_exp = '0;

    i2s_tdm_rx #(.WIDTH(16), .SLOT_BITS(16), .CHANNELS(2), .MODE(0)) u_a (
        .sclk(sclk), .rst(rst), .ws_i(ws), .sdata_i(sd), .frame_o(fr_a),
        .frame_valid_o(v_a), .frame_ready_i(rdy), .locked_o(lk_a),
        .frame_err_o(er_a), .overrun_o(ov_a));

    i2s_tdm_rx #(.WIDTH(16), .SLOT_BITS(16), .CHANNELS(2), .MODE(1)) u_b (
        .sclk(sclk), .rst(rst), .ws_i(ws), .sdata_i(sd), .frame_o(fr_b),
        .frame_valid_o(v_b), .frame_ready_i(rdy), .locked_o(lk_b),
        .frame_err_o(er_b), .overrun_o(ov_b));

    i2s_tdm_rx #(.WIDTH(24), .SLOT_BITS(32), .CHANNELS(4), .MODE(0)) u_c (
        .sclk(sclk), .rst(rst), .ws_i(ws), .sdata_i(sd), .frame_o(fr_c),
        .frame_valid_o(v_c), .frame_ready_i(rdy), .locked_o(lk_c),
        .frame_err_o(er_c), .overrun_o(ov_c));

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (er_a === 1'b1) er_a_n <= er_a_n + 1;
        if (ov_a === 1'b1) ov_a_n <= ov_a_n + 1;
        if (er_b === 1'b1) er_b_n <= er_b_n + 1;
        if (v_a === 1'b1 && vprev_a !== 1'b1) vr_a_n <= vr_a_n + 1;
        vprev_a <= v_a;
        if (chk_hold && v_a === 1'b1 && fr_a !== hold_exp) hold_bad <= hold_bad + 1;
    end

    task automatic settle();
        @(negedge sclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge sclk);
        rst = 1'b0; ws = 1'b1; sd = 1'b0; rdy = 1'b0;
        repeat (3) @(negedge sclk);
        rst = 1'b1;
        settle();
    endtask

    // Bits k0..k1-1 of a frame, MSB-first from bits[127]; ws low for the first slot
    task automatic send_bits(input logic [127:0] bits, input int total, input int slot,
                             input logic mode, input int k0, input int k1, input bit rdy_last);
        for (int k = k0; k < k1; k++) begin
            @(negedge sclk);
            ws = mode ? ((k % total) >= slot) : (((k + 1) % total) >= slot);
            sd = bits[127 - k];
            if (rdy_last && k == k1 - 1) rdy = 1'b1;
        end
    endtask

    task automatic preamble_i2s();
        @(negedge sclk); ws = 1'b1; sd = 1'b0;
        @(negedge sclk); ws = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge sclk);
        rst = 1'b0; ws = 1'b1; sd = 1'b0; rdy = 1'b0;
        #1;
        n_vec++; if (fr_a !== 32'h0) begin n_bad++; $display("FAIL rst_frame_a got %h want 0", fr_a); end
        n_vec++; if (v_a !== 1'b0) begin n_bad++; $display("FAIL rst_valid_a got %b want 0", v_a); end
        n_vec++; if (lk_a !== 1'b0) begin n_bad++; $display("FAIL rst_locked_a got %b want 0", lk_a); end
        n_vec++; if (er_a !== 1'b0 || ov_a !== 1'b0) begin n_bad++; $display("FAIL rst_pulses_a got %b%b want 00", er_a, ov_a); end
        n_vec++; if (fr_b !== 32'h0 || v_b !== 1'b0) begin n_bad++; $display("FAIL rst_frame_b got %h/%b want 0/0", fr_b, v_b); end
        n_vec++; if (lk_b !== 1'b0 || er_b !== 1'b0 || ov_b !== 1'b0) begin n_bad++; $display("FAIL rst_flags_b got %b%b%b want 000", lk_b, er_b, ov_b); end
        n_vec++; if (fr_c !== 96'h0 || v_c !== 1'b0) begin n_bad++; $display("FAIL rst_frame_c got %h/%b want 0/0", fr_c, v_c); end
        n_vec++; if (lk_c !== 1'b0 || er_c !== 1'b0 || ov_c !== 1'b0) begin n_bad++; $display("FAIL rst_flags_c got %b%b%b want 000", lk_c, er_c, ov_c); end
        repeat (2) @(negedge sclk);
        rst = 1'b1;
        settle();
    endtask

    task automatic test_i2s_basic();
        logic [127:0] b;
        int e0;
        b = {16'hDEAD, 16'hBEEF, 96'h0};
        do_reset();
        e0 = er_a_n;
        preamble_i2s();
        send_bits(b, 32, 16, 1'b0, 0, 31, 1'b0);
        settle();
        n_vec++; if (v_a !== 1'b0) begin n_bad++; $display("FAIL i2s_early_valid got %b want 0", v_a); end
        n_vec++; if (lk_a !== 1'b1) begin n_bad++; $display("FAIL i2s_locked got %b want 1", lk_a); end
        ws = 1'b0; sd = b[96];
        settle();
        n_vec++; if (v_a !== 1'b1) begin n_bad++; $display("FAIL i2s_valid got %b want 1", v_a); end
        n_vec++; if (fr_a !== 32'hBEEF_DEAD) begin n_bad++; $display("FAIL i2s_frame got %h want beefdead", fr_a); end
        n_vec++; if (er_a_n != e0) begin n_bad++; $display("FAIL i2s_no_err got %0d want 0", er_a_n - e0); end
        rdy = 1'b1;
        settle();
        n_vec++; if (v_a !== 1'b0) begin n_bad++; $display("FAIL i2s_accept got %b want 0", v_a); end
        rdy = 1'b0;
    endtask

    task automatic test_left_justified();
        int e0;
        do_reset();
        e0 = er_b_n;
        @(negedge sclk); ws = 1'b1; sd = 1'b0;
        send_bits({16'h1234, 16'hABCD, 96'h0}, 32, 16, 1'b1, 0, 32, 1'b0);
        settle();
        n_vec++; if (v_b !== 1'b1) begin n_bad++; $display("FAIL lj_valid got %b want 1", v_b); end
        n_vec++; if (fr_b !== 32'hABCD_1234) begin n_bad++; $display("FAIL lj_frame got %h want abcd1234", fr_b); end
        n_vec++; if (er_b_n != e0) begin n_bad++; $display("FAIL lj_no_err got %0d want 0", er_b_n - e0); end
        n_vec++; if (lk_b !== 1'b1) begin n_bad++; $display("FAIL lj_locked got %b want 1", lk_b); end
        // ws stays high: the expected sync edge is missing
        settle();
        n_vec++; if (er_b_n != e0 + 1) begin n_bad++; $display("FAIL lj_missing_fs_err got %0d want 1", er_b_n - e0); end
        n_vec++; if (lk_b !== 1'b0) begin n_bad++; $display("FAIL lj_unlock got %b want 0", lk_b); end
        n_vec++; if (fr_b !== 32'hABCD_1234 || v_b !== 1'b1) begin n_bad++; $display("FAIL lj_hold got %h/%b want abcd1234/1", fr_b, v_b); end
    endtask

    task automatic test_tdm();
        do_reset();
        preamble_i2s();
        send_bits({24'hA5A5A5, 8'hFF, 24'h123456, 8'hFF, 24'hFFFFFF, 8'hFF, 24'h000001, 8'hFF},
                  128, 32, 1'b0, 0, 128, 1'b0);
        settle();
        n_vec++; if (v_c !== 1'b1) begin n_bad++; $display("FAIL tdm_valid got %b want 1", v_c); end
        n_vec++; if (fr_c !== {24'h000001, 24'hFFFFFF, 24'h123456, 24'hA5A5A5}) begin
            n_bad++; $display("FAIL tdm_frame got %h want 000001ffffff123456a5a5a5", fr_c); end
        n_vec++; if (lk_c !== 1'b1) begin n_bad++; $display("FAIL tdm_locked got %b want 1", lk_c); end
    endtask

    task automatic test_sync_err();
        int e0, r0;
        do_reset();
        e0 = er_a_n; r0 = vr_a_n;
        preamble_i2s();
        send_bits({16'hFFFF, 16'hFFFF, 96'h0}, 32, 16, 1'b0, 0, 20, 1'b0);
        @(negedge sclk); ws = 1'b0; sd = 1'b0;
        send_bits({16'h5555, 16'hAAAA, 96'h0}, 32, 16, 1'b0, 0, 32, 1'b0);
        settle();
        n_vec++; if (er_a_n != e0 + 1) begin n_bad++; $display("FAIL sync_err_pulses got %0d want 1", er_a_n - e0); end
        n_vec++; if (vr_a_n != r0 + 1) begin n_bad++; $display("FAIL sync_frames got %0d want 1", vr_a_n - r0); end
        n_vec++; if (fr_a !== 32'hAAAA_5555) begin n_bad++; $display("FAIL sync_frame got %h want aaaa5555", fr_a); end
        n_vec++; if (lk_a !== 1'b1) begin n_bad++; $display("FAIL sync_locked got %b want 1", lk_a); end
    endtask

    task automatic test_overrun();
        int o0, h0;
        do_reset();
        o0 = ov_a_n; h0 = hold_bad;
        hold_exp = 32'h2222_1111;
        chk_hold = 1'b1;
        preamble_i2s();
        send_bits({16'h1111, 16'h2222, 96'h0}, 32, 16, 1'b0, 0, 32, 1'b0);
        send_bits({16'h3333, 16'h4444, 96'h0}, 32, 16, 1'b0, 0, 32, 1'b0);
        send_bits({16'h5A5A, 16'hC3C3, 96'h0}, 32, 16, 1'b0, 0, 32, 1'b0);
        settle();
        chk_hold = 1'b0;
        n_vec++; if (fr_a !== 32'h2222_1111) begin n_bad++; $display("FAIL ovr_frame got %h want 22221111", fr_a); end
        n_vec++; if (v_a !== 1'b1) begin n_bad++; $display("FAIL ovr_valid got %b want 1", v_a); end
        n_vec++; if (ov_a_n != o0 + 2) begin n_bad++; $display("FAIL ovr_pulses got %0d want 2", ov_a_n - o0); end
        n_vec++; if (hold_bad != h0) begin n_bad++; $display("FAIL ovr_hold_changes got %0d want 0", hold_bad - h0); end
        rdy = 1'b1;
        settle();
        n_vec++; if (v_a !== 1'b0) begin n_bad++; $display("FAIL ovr_accept got %b want 0", v_a); end
        rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        int o0, r0;
        do_reset();
        o0 = ov_a_n; r0 = vr_a_n;
        preamble_i2s();
        send_bits({16'h0001, 16'h8000, 96'h0}, 32, 16, 1'b0, 0, 32, 1'b0);
        send_bits({16'h7E7E, 16'h0FF0, 96'h0}, 32, 16, 1'b0, 0, 32, 1'b1);
        settle();
        rdy = 1'b0;
        n_vec++; if (fr_a !== 32'h0FF0_7E7E) begin n_bad++; $display("FAIL b2b_frame got %h want 0ff07e7e", fr_a); end
        n_vec++; if (v_a !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %b want 1", v_a); end
        n_vec++; if (ov_a_n != o0) begin n_bad++; $display("FAIL b2b_overrun got %0d want 0", ov_a_n - o0); end
        n_vec++; if (vr_a_n != r0 + 1) begin n_bad++; $display("FAIL b2b_valid_rises got %0d want 1", vr_a_n - r0); end
        settle();
        n_vec++; if (v_a !== 1'b1 || fr_a !== 32'h0FF0_7E7E) begin n_bad++; $display("FAIL b2b_held got %h/%b want 0ff07e7e/1", fr_a, v_a); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] b2;
        int r0;
        b2 = {16'hC0DE, 16'hF00D, 96'h0};
        do_reset();
        preamble_i2s();
        send_bits({16'h1111, 16'h2222, 96'h0}, 32, 16, 1'b0, 0, 32, 1'b0);
        send_bits(b2, 32, 16, 1'b0, 0, 8, 1'b0);
        @(negedge sclk);
        rst = 1'b0;
        #1;
        n_vec++; if (fr_a !== 32'h0 || v_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_frame got %h/%b want 0/0", fr_a, v_a); end
        n_vec++; if (lk_a !== 1'b0 || er_a !== 1'b0 || ov_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags got %b%b%b want 000", lk_a, er_a, ov_a); end
        @(negedge sclk);
        rst = 1'b1;
        #1;
        r0 = vr_a_n;
        send_bits(b2, 32, 16, 1'b0, 8, 32, 1'b0);
        send_bits({16'h0F0F, 16'h7777, 96'h0}, 32, 16, 1'b0, 0, 32, 1'b0);
        settle();
        n_vec++; if (vr_a_n != r0 + 1) begin n_bad++; $display("FAIL mid_rst_frames got %0d want 1", vr_a_n - r0); end
        n_vec++; if (fr_a !== 32'h7777_0F0F || v_a !== 1'b1) begin n_bad++; $display("FAIL mid_rst_frame_after got %h/%b want 77770f0f/1", fr_a, v_a); end
    endtask

    initial begin
        rst = 1'b0; ws = 1'b1; sd = 1'b0; rdy = 1'b0;
        test_reset();
        test_i2s_basic();
        test_left_justified();
        test_tdm();
        test_sync_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
